sram_march_bist: RTL
====================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 Parameter NUM_WORDS, default 2048; number of 32-bit words tested.
REQ-002 Parameter ADDR_WIDTH, default 13; byte-address width of the memory port.
REQ-003 Parameter DATA_WIDTH, default 32; memory data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  run request, sampled only in IDLE or DONE.
REQ-007 busy_o  output  1  high while a run is in progress.
REQ-008 done_o  output  1  high from run completion until the next start or reset.
REQ-009 fail_o  output  1  sticky; high if any read compare mismatched this run.
REQ-010 fail_addr_o  output  $clog2(NUM_WORDS)  word index of the first mismatch.
REQ-011 fail_data_o  output  DATA_WIDTH  read data captured at the first mismatch.
REQ-012 mem_en_o  output  1  memory enable, active-high.
REQ-013 mem_we_o  output  1  write enable, active-high; low means read.
REQ-014 mem_be_o  output  DATA_WIDTH/8  byte enables; all ones whenever mem_en_o is high.
REQ-015 mem_addr_o  output  ADDR_WIDTH  byte address = word index << 2, bits [1:0] always 0.
REQ-016 mem_wdata_o  output  DATA_WIDTH  write data.
REQ-017 mem_rdata_i  input  DATA_WIDTH  read data, valid the cycle after a read access.

Function
REQ-018 The block SHALL execute March C- over word indices 0..NUM_WORDS-1, using P0=32'h0000_0000 and P1=32'hFFFF_FFFF.
REQ-019 The element sequence SHALL be M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-020 The state machine SHALL have states IDLE, M0..M5, DRAIN and DONE.
REQ-021 IDLE/DONE with start_i=1 SHALL move to M0 at the next edge, clearing done_o, fail_o, fail_addr_o and fail_data_o.
REQ-022 M0 SHALL issue one write per cycle, with no idle cycles.
REQ-023 Each read/write element SHALL take 2 cycles per word: read at index a, then write at index a in the next cycle.
REQ-024 M5 SHALL issue one read per cycle.
REQ-025 Every read SHALL be compared to the expected pattern in the following cycle.
REQ-026 DRAIN SHALL be one cycle with mem_en_o low, used only to compare the last M5 read.
REQ-027 Element transitions SHALL be back-to-back, with no gap cycles; up elements start at index 0, down elements start at NUM_WORDS-1.
REQ-028 Latency: a run SHALL issue exactly 10*NUM_WORDS accesses (5*NUM_WORDS writes, 5*NUM_WORDS reads).
REQ-029 Latency: done_o SHALL first be high in cycle 10*NUM_WORDS+2 after the edge that sampled start_i; busy_o SHALL be high in cycles 1..10*NUM_WORDS+1.
REQ-030 On the first mismatch, fail_o SHALL set and fail_addr_o/fail_data_o SHALL be captured; later mismatches SHALL NOT overwrite them.
REQ-031 The run SHALL continue to completion after a mismatch.
REQ-032 start_i while busy_o=1 SHALL be ignored.
REQ-033 start_i held high in DONE SHALL restart a run.
REQ-034 mem_en_o SHALL be low in IDLE, DRAIN and DONE; mem_we_o, mem_be_o and mem_wdata_o SHALL be 0 whenever mem_en_o is low.
REQ-035 The address counter SHALL never leave 0..NUM_WORDS-1; wrap at an element boundary SHALL be by reload, not overflow.

Reset
REQ-036 While rst=1, the FSM SHALL be in IDLE and every output SHALL be 0, asynchronously; a run in progress SHALL be aborted with no further memory access.
REQ-037 After rst deasserts, the block SHALL wait for start_i; no partial results SHALL be retained.

Structure
REQ-038 Package sram_bist_pkg SHALL hold the FSM state enum, the march-element descriptor typedef (direction, op sequence, read/write patterns) and the P0/P1 constants.
REQ-039 Sub-module sram_bist_addr_gen SHALL implement the loadable up/down word counter with a last-index flag; the FSM, compare and capture logic SHALL remain in sram_march_bist.

Verification (NUM_WORDS=16, behavioural 1-cycle-latency memory model)
REQ-040 Fault-free memory, 1-cycle start_i pulse -> done_o first high in cycle 162, fail_o=0, 80 writes and 80 reads, every mem_be_o=4'hF.
REQ-041 Word 7 bit 5 stuck-at-0 -> fail_o=1, fail_addr_o=7, fail_data_o=32'hFFFF_FFDF (first detected in M2), done_o still in cycle 162.
REQ-042 First cycle of M3 -> mem_addr_o=13'h003C, mem_we_o=0; next cycle mem_addr_o=13'h003C, mem_we_o=1, mem_wdata_o=32'hFFFF_FFFF.
REQ-043 start_i pulse in cycle 50 of a run -> ignored, done_o still in cycle 162.
REQ-044 rst asserted in cycle 80 -> same-cycle mem_en_o=0, busy_o=0; a subsequent start passes with fail_o=0.
REQ-045 Failed run followed by start_i in DONE on a fixed memory -> fail_o, fail_addr_o and fail_data_o clear; run passes.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM March C- BIST.
// Holds the FSM state enum, the march-element descriptor (direction,
// operation sequence, read/write data backgrounds) and the two data
// backgrounds P0/P1, plus small helpers that describe the element order.
package sram_bist_pkg;

    localparam int unsigned PAT_WIDTH = 32;
    localparam logic [PAT_WIDTH-1:0] P0 = 32'h0000_0000;
    localparam logic [PAT_WIDTH-1:0] P1 = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } march_dir_e;

    // Operation sequence applied to each word of an element.
    typedef enum logic [1:0] {
        OPS_W,     // single write
        OPS_RW,    // read then write of the same word
        OPS_R,     // single read
        OPS_NONE
    } march_ops_e;

    typedef struct packed {
        march_dir_e             dir;
        march_ops_e             ops;
        logic [PAT_WIDTH-1:0]   rd_pat;
        logic [PAT_WIDTH-1:0]   wr_pat;
    } march_elem_t;

    // March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0)
    function automatic march_elem_t march_elem(input bist_state_e st);
        march_elem_t e;
        e = '{dir: DIR_UP, ops: OPS_NONE, rd_pat: P0, wr_pat: P0};
        case (st)
            ST_M0: begin e.ops = OPS_W;  e.wr_pat = P0; end
            ST_M1: begin e.ops = OPS_RW; e.rd_pat = P0; e.wr_pat = P1; end
            ST_M2: begin e.ops = OPS_RW; e.rd_pat = P1; e.wr_pat = P0; end
            ST_M3: begin e.dir = DIR_DOWN; e.ops = OPS_RW; e.rd_pat = P0; e.wr_pat = P1; end
            ST_M4: begin e.dir = DIR_DOWN; e.ops = OPS_RW; e.rd_pat = P1; e.wr_pat = P0; end
            ST_M5: begin e.ops = OPS_R;  e.rd_pat = P0; end
            default: ;
        endcase
        return e;
    endfunction

    // State that follows a march element; M5 hands over to DRAIN.
    function automatic bist_state_e march_next(input bist_state_e st);
        case (st)
            ST_M0:   return ST_M1;
            ST_M1:   return ST_M2;
            ST_M2:   return ST_M3;
            ST_M3:   return ST_M4;
            ST_M4:   return ST_M5;
            ST_M5:   return ST_DRAIN;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic march_dir_e march_dir(input bist_state_e st);
        march_elem_t e;
        e = march_elem(st);
        return e.dir;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down word-index counter for the march BIST.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       reload the counter (wins over step_i)
//   load_dir_i   direction of the element being entered: UP loads 0,
//                DOWN loads NUM_WORDS-1
//   step_i       advance one word in direction dir_i
//   dir_i        direction of the element currently running
//   addr_o       current word index
//   last_o       addr_o is the final index for direction dir_i
// The controller reloads at every element boundary instead of stepping
// past the end, so the index always stays within 0..NUM_WORDS-1.
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 2048,
    parameter int unsigned AW        = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  march_dir_e    load_dir_i,
    input  logic          step_i,
    input  march_dir_e    dir_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = (load_dir_i == DIR_DOWN) ? LAST_IDX : '0;
        end else if (step_i) begin
            addr_d = (dir_i == DIR_DOWN) ? addr_q - AW'(1) : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (dir_i == DIR_DOWN) ? (addr_q == '0) : (addr_q == LAST_IDX);

endmodule

// File: rtl/sram_march_bist.sv
// March C- built-in self test for a single-port word SRAM.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (aborts a run)
//   start_i       run request, honoured only in IDLE or DONE
//   busy_o        run in progress
//   done_o        run complete; held until the next start or reset
//   fail_o        sticky mismatch flag for the current run
//   fail_addr_o   word index of the first mismatch
//   fail_data_o   read data captured at the first mismatch
//   mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
//                 memory request (byte address = word index << 2)
//   mem_rdata_i   read data, valid the cycle after a read access
// Each read is checked one cycle later against the background recorded
// when it was issued; DRAIN exists only to check the final M5 read.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 2048,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         fail_o,
    output logic [$clog2(NUM_WORDS)-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0]        fail_data_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [DATA_WIDTH/8-1:0]      mem_be_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int unsigned AW = $clog2(NUM_WORDS);

    bist_state_e     state_q, state_d;
    logic            phase_q, phase_d;          // 0: read slot, 1: write slot of an r,w pair
    logic            cmp_vld_q, cmp_vld_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
    logic            fail_q, fail_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    march_elem_t     elem;
    logic            slot_done;
    logic            ag_load;
    march_dir_e      ag_load_dir;
    logic            ag_step;
    logic [AW-1:0]   word_addr;
    logic            word_last;
    logic            en;
    logic            we;
    logic [DATA_WIDTH-1:0] wdata;

    sram_bist_addr_gen #(
        .NUM_WORDS (NUM_WORDS),
        .AW        (AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ag_load),
        .load_dir_i (ag_load_dir),
        .step_i     (ag_step),
        .dir_i      (elem.dir),
        .addr_o     (word_addr),
        .last_o     (word_last)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ag_load     = 1'b0;
        ag_load_dir = DIR_UP;
        ag_step     = 1'b0;
        en          = 1'b0;
        we          = 1'b0;
        wdata       = '0;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = '0;
        cmp_addr_d  = word_addr;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        slot_done   = 1'b0;
        elem        = march_elem(state_q);

        // Only the first mismatch of a run is recorded.
        if (cmp_vld_q && (mem_rdata_i != cmp_exp_q) && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_data_d = mem_rdata_i;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_M0;
                    phase_d     = 1'b0;
                    ag_load     = 1'b1;
                    ag_load_dir = DIR_UP;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                en = 1'b1;
                case (elem.ops)
                    OPS_W: begin
                        we        = 1'b1;
                        slot_done = 1'b1;
                    end
                    OPS_R: begin
                        slot_done = 1'b1;
                    end
                    OPS_RW: begin
                        we        = phase_q;
                        phase_d   = ~phase_q;
                        slot_done = phase_q;
                    end
                    default: begin
                        slot_done = 1'b1;
                    end
                endcase
                // Element boundaries reload the counter so the next element
                // starts in the same cycle with no gap.
                if (slot_done) begin
                    if (word_last) begin
                        state_d     = march_next(state_q);
                        ag_load     = 1'b1;
                        ag_load_dir = march_dir(march_next(state_q));
                    end else begin
                        ag_step = 1'b1;
                    end
                end
                if (we) begin
                    wdata = DATA_WIDTH'(elem.wr_pat);
                end else begin
                    cmp_vld_d = 1'b1;
                    cmp_exp_d = DATA_WIDTH'(elem.rd_pat);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
    assign mem_en_o    = en;
    assign mem_we_o    = we;
    assign mem_be_o    = en ? '1 : '0;
    assign mem_addr_o  = en ? ADDR_WIDTH'({word_addr, 2'b00}) : '0;
    assign mem_wdata_o = wdata;

endmodule
